// File: rtl/adder_seq_ctrl.sv
// Sequencer for a shared 8-bit adder: ADD, SUB (two's complement), MUL.
// Define ADDER_SEQ_MUL_EN to build in the shift-add multiplier.
module adder_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  input  logic [7:0]  add_sum,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    NEG,
    SUB,
    MUL,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] t;
  logic       c1;

`ifdef ADDER_SEQ_MUL_EN
  logic [15:0] p;
  logic [2:0]  cnt;
  logic [15:0] pn;

  assign pn = {add_cout, add_sum, p[7:1]};
`endif

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      ADD: begin
        add_a = ra;
        add_b = rb;
      end
      NEG: begin
        add_a = ~rb;
        add_b = 8'h01;
      end
      SUB: begin
        add_a = ra;
        add_b = t;
      end
`ifdef ADDER_SEQ_MUL_EN
      MUL: begin
        add_a = p[15:8];
        add_b = p[0] ? ra : 8'h00;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
      ra     <= '0;
      rb     <= '0;
      t      <= '0;
      c1     <= 1'b0;
`ifdef ADDER_SEQ_MUL_EN
      p      <= '0;
      cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra   <= a;
            rb   <= b;
            err  <= 1'b0;
            busy <= 1'b1;
            case (op)
              2'b00: state <= ADD;
              2'b01: state <= NEG;
`ifdef ADDER_SEQ_MUL_EN
              2'b10: begin
                state <= MUL;
                p     <= {8'h00, b};
                cnt   <= '0;
              end
`endif
              default: begin
                state  <= DONE;
                result <= '0;
                carry  <= 1'b0;
                err    <= 1'b1;
                done   <= 1'b1;
              end
            endcase
          end
        end
        ADD: begin
          result <= {8'h00, add_sum};
          carry  <= add_cout;
          done   <= 1'b1;
          state  <= DONE;
        end
        NEG: begin
          t     <= add_sum;
          c1    <= add_cout;
          state <= SUB;
        end
        SUB: begin
          result <= {8'h00, add_sum};
          carry  <= c1 | add_cout;
          done   <= 1'b1;
          state  <= DONE;
        end
`ifdef ADDER_SEQ_MUL_EN
        MUL: begin
          p <= pn;
          // last of eight iterations; never let cnt wrap into a ninth
          if (cnt == 3'd7) begin
            result <= pn;
            carry  <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a behavioural shared adder.
// Covers MUL when ADDER_SEQ_MUL_EN is defined, reserved op=10 otherwise.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b);

  adder_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .err      (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  // latency counts edges from the start edge (=1) until done is seen
  task automatic run(input logic [1:0] o,
                     input logic [7:0] x,
                     input logic [7:0] y,
                     output int lat);
    wait_idle();
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic reset_outs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_res"}, {16'd0, result}, 32'd0);
    check({tag, "_carry"}, {31'd0, carry}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_adda"}, {24'd0, add_a}, 32'd0);
    check({tag, "_addb"}, {24'd0, add_b}, 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_outs("rst");
    @(negedge clk);
    rst = 1'b0;

    // ADD with carry-out
    run(2'b00, 8'hC8, 8'h64, lat);
    check("add_lat", lat, 2);
    check("add_res", {16'd0, result}, 32'h002C);
    check("add_carry", {31'd0, carry}, 1);
    check("add_err", {31'd0, err}, 0);
    @(posedge clk);
    #1;
    check("add_done_pulse", {31'd0, done}, 0);
    check("add_busy_clr", {31'd0, busy}, 0);
    check("hold_res", {16'd0, result}, 32'h002C);

    // SUB with borrow and without
    run(2'b01, 8'h05, 8'h07, lat);
    check("sub1_lat", lat, 3);
    check("sub1_res", {16'd0, result}, 32'h00FE);
    check("sub1_carry", {31'd0, carry}, 0);
    run(2'b01, 8'h10, 8'h00, lat);
    check("sub2_lat", lat, 3);
    check("sub2_res", {16'd0, result}, 32'h0010);
    check("sub2_carry", {31'd0, carry}, 1);

    // reserved op, then err clears on next accepted ADD
    run(2'b11, 8'h12, 8'h34, lat);
    check("rsv_lat", lat, 1);
    check("rsv_err", {31'd0, err}, 1);
    check("rsv_res", {16'd0, result}, 0);
    check("rsv_carry", {31'd0, carry}, 0);
    run(2'b00, 8'h01, 8'h02, lat);
    check("clr_err", {31'd0, err}, 0);
    check("clr_res", {16'd0, result}, 32'h0003);

`ifdef ADDER_SEQ_MUL_EN
    run(2'b10, 8'hFF, 8'hFF, lat);
    check("mul1_lat", lat, 9);
    check("mul1_res", {16'd0, result}, 32'hFE01);
    check("mul1_carry", {31'd0, carry}, 0);
    check("mul1_err", {31'd0, err}, 0);
    run(2'b10, 8'h00, 8'hAB, lat);
    check("mul2_lat", lat, 9);
    check("mul2_res", {16'd0, result}, 0);
    run(2'b10, 8'h0D, 8'h0B, lat);
    check("mul3_res", {16'd0, result}, 32'h008F);
`else
    run(2'b10, 8'hFF, 8'hFF, lat);
    check("mul_off_lat", lat, 1);
    check("mul_off_err", {31'd0, err}, 1);
    check("mul_off_res", {16'd0, result}, 0);
`endif

    // start held high through SUB while operands and op change
    wait_idle();
    op = 2'b01;
    a = 8'h20;
    b = 8'h05;
    start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      op = 2'b00;
      a = 8'hFF;
      b = 8'hFF;
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (k == 2) begin
        check("hold_done_at3", {31'd0, done}, 1);
        check("hold_res", {16'd0, result}, 32'h001B);
        check("hold_carry", {31'd0, carry}, 1);
      end
    end
    check("hold_ndone", ndone, 1);
    check("hold_idle", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    check("hold_reaccept", {31'd0, busy}, 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold2_done", {31'd0, done}, 1);
    check("hold2_res", {16'd0, result}, 32'h00FE);

    // asynchronous reset in the middle of a long operation
    wait_idle();
`ifdef ADDER_SEQ_MUL_EN
    op = 2'b10;
`else
    op = 2'b01;
`endif
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef ADDER_SEQ_MUL_EN
    repeat (3) @(posedge clk);
`endif
    #2;
    rst = 1'b1;
    #1;
    reset_outs("abort");
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run(2'b00, 8'h01, 8'h01, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_res", {16'd0, result}, 32'h0002);
    check("post_rst_carry", {31'd0, carry}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: 00 ADD, 01 SUB, 10 MUL (unsigned), 11 reserved.
REQ-005 The block SHALL have the ports a and b, input, 8 bits each: operands, sampled with start.
REQ-006 The block SHALL have the ports add_a and add_b, output, 8 bits each: operands driven to the shared 8-bit ripple adder (carry-in fixed 0).
REQ-007 The block SHALL have the ports add_sum, input, 8 bits, and add_cout, input, 1 bit: combinational sum and carry-out returned by the shared adder.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking result, carry and err valid.
REQ-010 The block SHALL have the port result, output, 16 bits: ADD/SUB in [7:0] with [15:8]=0; MUL full product.
REQ-011 The block SHALL have the port carry, output, 1 bit: ADD carry-out; SUB no-borrow (1 when a>=b); 0 for MUL.
REQ-012 The block SHALL have the port err, output, 1 bit: op was reserved or disabled.

Function
REQ-013 The FSM SHALL have the states IDLE, ADD, NEG, SUB, MUL, DONE; start with op latched in IDLE SHALL transition to ADD, NEG, MUL or DONE (err) respectively.
REQ-014 ADD SHALL drive add_a=A, add_b=B and register sum and add_cout, then go to DONE; done SHALL be high 2 cycles after the start edge.
REQ-015 NEG SHALL drive add_a=~B, add_b=8'h01 and register T=add_sum, c1=add_cout; SUB SHALL drive add_a=A, add_b=T and register sum, carry=c1|add_cout; done SHALL be high 3 cycles after the start edge.
REQ-016 MUL SHALL initialise P={8'h00,B} and run exactly 8 cycles, each driving add_a=P[15:8], add_b=(P[0]?A:0) and loading P={add_cout,add_sum,P[7:1]}; after the 8th cycle it SHALL go to DONE, so done SHALL be high 9 cycles after the start edge.
REQ-017 The iteration counter SHALL be 3 bits, cleared on MUL entry, and exit on value 7 without wrap-around into a 9th iteration.
REQ-018 In IDLE and DONE, add_a and add_b SHALL be 0.
REQ-019 DONE SHALL last one cycle, assert done, and return to IDLE; start during any busy state including DONE SHALL be ignored and not queued.
REQ-020 A reserved op SHALL go IDLE->DONE with result=0, carry=0, err=1, giving done 1 cycle after the start edge.
REQ-021 result, carry and err SHALL hold their last values until the next accepted start, at which point err SHALL clear.
REQ-022 Operands SHALL be latched at the start edge; changes on a/b/op while busy SHALL have no effect.

Reset
REQ-023 rst SHALL immediately force IDLE, busy=0, done=0, result=16'h0000, carry=0, err=0, add_a=add_b=0, counter=0, regardless of any operation in flight.
REQ-024 An operation aborted by rst SHALL never produce done; the first start after rst deassertion SHALL be accepted normally.

Configuration
REQ-025 With macro ADDER_SEQ_MUL_EN defined, the MUL state and product register SHALL be compiled in and op=10 SHALL behave as in REQ-016.
REQ-026 Without ADDER_SEQ_MUL_EN, the MUL logic SHALL be absent and op=10 SHALL be handled exactly as reserved per REQ-020.

Verification
REQ-027 For ADD a=8'hC8, b=8'h64 -> done at cycle +2, result=16'h002C, carry=1, err=0.
REQ-028 For SUB a=8'h05, b=8'h07 -> done at +3, result=16'h00FE, carry=0; for a=8'h10, b=8'h00 -> result=16'h0010, carry=1.
REQ-029 For MUL (macro on) a=8'hFF, b=8'hFF -> done at +9, result=16'hFE01; for a=8'h00, b=8'hAB -> result=16'h0000.
REQ-030 For op=11, and op=10 with the macro off -> done at +1, err=1, result=0; the next valid ADD SHALL clear err.
REQ-031 For rst asserted at MUL iteration 4, then start ADD a=1, b=1 -> no done for the aborted MUL, all outputs 0 during reset, ADD result=16'h0002.
REQ-032 For start held high continuously with changing a/b during SUB -> only one done, the result SHALL match the operands latched at acceptance, and the next start SHALL be accepted in the IDLE cycle after DONE.
